// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit sharing one shift/add datapath, one result bit per cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies finish in one cycle via a combinational product.
module muldiv_unit #(
  parameter int Size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      Control,
  input  logic [Size-1:0] a,
  input  logic [Size-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [Size-1:0] out
);

  localparam int AccW = 2*Size + 1;
  localparam int CntW = $clog2(Size + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q;
  logic            neg_a_q, neg_b_q;
  logic [CntW-1:0] cnt_q;
  logic [AccW-1:0] acc_q, acc_next;
  logic [Size-1:0] m_q;

  // Request decode, evaluated while idle
  op_t             op_in;
  logic            is_div_in, a_signed, b_signed, neg_a_in, neg_b_in;
  logic [Size-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special, fast_mul, direct;
  logic [Size-1:0] special_result, fast_result;

  // Sign correction and half/quotient/remainder selection from a raw magnitude result
  function automatic logic [Size-1:0] format_result(
    input op_t               op,
    input logic              neg_a,
    input logic              neg_b,
    input logic [2*Size-1:0] raw
  );
    logic [2*Size-1:0] prod;
    logic [Size-1:0]   quo, rem;
    prod = (neg_a ^ neg_b) ? -raw : raw;
    quo  = (neg_a ^ neg_b) ? -raw[Size-1:0] : raw[Size-1:0];
    rem  = neg_a ? -raw[2*Size-1:Size] : raw[2*Size-1:Size];
    case (op)
      OP_MUL:                      format_result = prod[Size-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: format_result = prod[2*Size-1:Size];
      OP_DIV, OP_DIVU:             format_result = quo;
      default:                     format_result = rem;
    endcase
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    op_in     = op_t'(Control);
    is_div_in = Control[2];
    a_signed  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed  = op_in inside {OP_MULH, OP_DIV, OP_REM};
    neg_a_in  = a_signed && a[Size-1];
    neg_b_in  = b_signed && b[Size-1];
    a_mag     = neg_a_in ? -a : a;
    b_mag     = neg_b_in ? -b : b;
    div_zero  = is_div_in && (b == '0);
    div_ovf   = is_div_in && b_signed && (a == {1'b1, {(Size-1){1'b0}}}) && (b == '1);
    special   = div_zero || div_ovf;
  end

  // Control[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    special_result = '0;
    if (div_zero)     special_result = Control[1] ? a : '1;
    else if (div_ovf) special_result = Control[1] ? '0 : a;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*Size-1:0] fast_prod;
  assign fast_prod   = {{Size{1'b0}}, a_mag} * {{Size{1'b0}}, b_mag};
  assign fast_mul    = !is_div_in;
  assign fast_result = format_result(op_in, neg_a_in, neg_b_in, fast_prod);
`else
  assign fast_mul    = 1'b0;
  assign fast_result = '0;
`endif

  assign direct = special || fast_mul;

  // One iteration of the shared datapath: shift-add for multiply, restoring step for divide
  logic [Size:0]   upper;
  logic [Size+1:0] trial;
  logic [AccW-1:0] shifted;

  always_comb begin
    acc_next = acc_q;
    upper    = '0;
    trial    = '0;
    shifted  = '0;
    if (op_q[2]) begin
      shifted  = {acc_q[AccW-2:0], 1'b0};
      trial    = {1'b0, shifted[AccW-1:Size]} - {2'b00, m_q};
      acc_next = shifted;
      if (!trial[Size+1]) begin
        acc_next    = {trial[Size:0], shifted[Size-1:0]};
        acc_next[0] = 1'b1;
      end
    end else begin
      upper    = acc_q[AccW-1:Size] + (acc_q[0] ? {1'b0, m_q} : '0);
      acc_next = {1'b0, upper, acc_q[Size-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = direct ? FINISH : RUN;
      RUN:     if (cnt_q == CntW'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset as well, so nothing undefined can leak into out.
      state_q <= IDLE;
      op_q    <= OP_MUL;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op_in;
            neg_a_q <= neg_a_in;
            neg_b_q <= neg_b_in;
            cnt_q   <= CntW'(Size);
            if (is_div_in) begin
              acc_q <= {{(Size+1){1'b0}}, a_mag};
              m_q   <= b_mag;
            end else begin
              acc_q <= {{(Size+1){1'b0}}, b_mag};
              m_q   <= a_mag;
            end
            if (special)       out <= special_result;
            else if (fast_mul) out <= fast_result;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1))
            out <= format_result(op_q, neg_a_q, neg_b_q, acc_next[AccW-2:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, control scenarios and
// randomized operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  control;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] out_w;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.Size(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .Control(control),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .out    (out_w)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference results from the RV32M definitions using 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    r  = '0;
    case (op)
      3'b000: begin r = ux * uy; return r[31:0];  end
      3'b001: begin r = sx * sy; return r[63:32]; end
      3'b010: begin r = sx * uy; return r[63:32]; end
      3'b011: begin r = ux * uy; return r[63:32]; end
      3'b100: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        r = sx / sy; return r[31:0];
      end
      3'b101: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        r = ux / uy; return r[31:0];
      end
      3'b110: begin
        if (y == 32'h0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        r = sx % sy; return r[31:0];
      end
      default: begin
        if (y == 32'h0) return x;
        r = ux % uy; return r[31:0];
      end
    endcase
  endfunction

  // Cycle index (first busy cycle = 1) at which done is expected
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op[2]) begin
      if (y == 32'h0) return 1;
      if ((op == 3'b100 || op == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] expected);
    int c;
    bit busy_ok;
    start   = 1'b1;
    control = op;
    a       = x;
    b       = y;
    tick();
    start   = 1'b0;
    control = 3'($urandom_range(0, 7));
    a       = $urandom;
    b       = $urandom;
    c       = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && c < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      c++;
    end
    check({tag, " latency"}, c, lat_of(op, x, y));
    check({tag, " out"}, out_w, expected);
    check({tag, " busy"}, {31'b0, busy_ok & busy}, 32'd1);
    tick();
    check({tag, " done/busy drop"}, {30'b0, done, busy}, 32'd0);
    check({tag, " out hold"}, out_w, expected);
  endtask

  initial begin
    int c;
    bit saw_done;
    logic [2:0]  rop;
    logic [31:0] rx, ry;

    rst = 1'b1; start = 1'b0; control = 3'b000; a = '0; b = '0;
    tick();
    tick();
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset out", out_w, 32'd0);
    rst = 1'b0;
    tick();

    run_op("mul neg",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh minmin",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op("mulhu ones",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu ones",    3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div -7/2",       3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_op("rem -7/2",       3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_op("divu",           3'b101, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC);
    run_op("div by zero",    3'b100, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF);
    run_op("remu by zero",   3'b111, 32'h0000_1234,  32'd0,         32'h0000_1234);
    run_op("div overflow",   3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem overflow",   3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);

    // A start while busy is dropped, as is a start during the done cycle
    start = 1'b1; control = 3'b101; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < 100) begin
      if (c == 5) begin
        start = 1'b1; control = 3'b000; a = 32'd2; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      c++;
    end
    check("busy-start latency", c, 32'd33);
    check("busy-start out", out_w, 32'd14);
    start = 1'b1; control = 3'b000; a = 32'd2; b = 32'd3;
    tick();
    check("done-cycle start ignored", {30'b0, done, busy}, 32'd0);
    run_op("mul after done", 3'b000, 32'd2, 32'd3, 32'd6);

    // Reset aborts a divide in flight; reset also wins over a simultaneous start
    start = 1'b1; control = 3'b100; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    c = 1;
    while (c < 10) begin
      tick();
      c++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c++;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort out", out_w, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    rst = 1'b1; start = 1'b1; control = 3'b000; a = 32'd5; b = 32'd5;
    tick();
    rst = 1'b0; start = 1'b0;
    c++;
    check("rst+start busy", {31'b0, busy}, 32'd0);
    saw_done = 1'b0;
    while (c <= 40) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
      c++;
    end
    check("no done after abort", {31'b0, saw_done}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rx  = $urandom;
      ry  = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'h0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 15));
        3: rx = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, rop), rop, rx, ry, ref_model(rop, rx, ry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
